note_dds: RTL and testbench

NOTE_DDS -- requirements
Module: note_dds

---
 rtl/note_dds.sv | 101 ++++++++++
 tb/tb_note_dds.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/note_dds.sv
// rtl/note_dds.sv - MIDI note number to phase-increment DDS with a free-running phase accumulator
//
// Purpose:
//   Converts a MIDI note number into a 32-bit phase increment and accumulates it
//   every clock, producing a sawtooth phase whose wrap rate is the note frequency.
//   Frequency = ADDER * CLK_HZ / 2^32.
//
// Parameters:
//   CLK_HZ  clock frequency in Hz; the increment table is derived from it at elaboration.
//
// Ports:
//   CLK     rising-edge clock for all state
//   RESET   asynchronous, active-low reset; clears ADDER and DDS
//   NOTE    MIDI note number (69 = A4 = 440 Hz); values >= 128 select a zero increment
//   ADDER   registered phase increment for NOTE (one cycle behind NOTE)
//   DDS     registered phase accumulator, modulo 2^32; DDS[31:24] is an 8-bit sawtooth

module note_dds #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  NOTE,
    output logic [31:0] ADDER,
    output logic [31:0] DDS
);

    // Octave-10 note frequencies (MIDI 120..131) in micro-hertz, rounded.
    // Lower octaves are obtained by right-shifting the derived increments.
    localparam logic [63:0] F_UHZ [12] = '{
        64'd8372018090,   // C10
        64'd8869844191,   // C#10
        64'd9397272573,   // D10
        64'd9956063479,   // D#10
        64'd10548081821,  // E10
        64'd11175303406,  // F10
        64'd11839821527,  // F#10
        64'd12543853951,  // G10
        64'd13289750323,  // G#10
        64'd14080000000,  // A10
        64'd14917240369,  // A#10
        64'd15804265640   // B10
    };

    // Clock frequency expressed in micro-hertz so it shares the table's scale.
    localparam logic [127:0] DEN = 128'(CLK_HZ) * 128'd1000000;

    // Octave-10 increment table: round(f * 2^32 / CLK_HZ), folded to constants.
    logic [31:0] tbl [12];

    for (genvar g = 0; g < 12; g++) begin : g_tbl
        localparam logic [127:0] NUM = (128'(F_UHZ[g]) << 32) + (DEN >> 1);
        localparam logic [127:0] QUO = NUM / DEN;
        assign tbl[g] = QUO[31:0];
    end

    logic [6:0]  note_lo;
    logic [3:0]  octave;
    logic [3:0]  semitone;
    logic [3:0]  shift_amt;
    logic [31:0] increment;

    logic [31:0] adder_d;
    logic [31:0] adder_q;
    logic [31:0] dds_d;
    logic [31:0] dds_q;

    // Note decode: octave/semitone split and table lookup with octave shift.
    always_comb begin
        note_lo   = NOTE[6:0];
        octave    = 4'(note_lo / 7'd12);
        semitone  = 4'(note_lo % 7'd12);
        // octave is at most 10 for notes 0..127, so this never underflows
        shift_amt = 4'd10 - octave;
        increment = tbl[semitone] >> shift_amt;
        if (NOTE[7]) begin
            increment = 32'd0;
        end
    end

    // Next-state: the accumulator adds the registered increment, so a new note
    // only changes the slope and never disturbs the current phase.
    always_comb begin
        adder_d = increment;
        dds_d   = dds_q + adder_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            adder_q <= 32'd0;
            dds_q   <= 32'd0;
        end else begin
            adder_q <= adder_d;
            dds_q   <= dds_d;
        end
    end

    assign ADDER = adder_q;
    assign DDS   = dds_q;

endmodule

// File: tb/tb_note_dds.sv
// tb/tb_note_dds.sv - directed self-checking bench for note_dds

module tb_note_dds;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  note_a;
    logic [7:0]  note_b;
    logic [7:0]  note_c;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic [31:0] adder_c;
    logic [31:0] dds_a;
    logic [31:0] dds_b;
    logic [31:0] dds_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    note_dds u_dds_a (.CLK(clk), .RESET(rst_n), .NOTE(note_a), .ADDER(adder_a), .DDS(dds_a));
    note_dds u_dds_b (.CLK(clk), .RESET(rst_n), .NOTE(note_b), .ADDER(adder_b), .DDS(dds_b));
    note_dds u_dds_c (.CLK(clk), .RESET(rst_n), .NOTE(note_c), .ADDER(adder_c), .DDS(dds_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ratio-run models: hand-computed increments for notes 93/105/117.
    localparam int RUN_CYCLES = 60000;
    logic [31:0] inc_m [3];
    logic [31:0] dds_m [3];
    logic [32:0] sum_m;
    logic [31:0] prev_dut [3];
    logic [31:0] now_dut [3];
    int          wraps_m [3];
    int          wraps_d [3];
    int          wc_fail;

    initial begin
        rst_n  = 1'b0;
        note_a = 8'd69;
        note_b = 8'd57;
        note_c = 8'd81;

        repeat (5) tick();
        check("reset_adder_a", adder_a, 32'd0);
        check("reset_dds_a",   dds_a,   32'd0);
        check("reset_adder_c", adder_c, 32'd0);

        // Release: ADDER loads on the first edge, DDS ramps from the second.
        rst_n = 1'b1;
        tick();
        check("rel_adder_69", adder_a, 32'd37795);
        check("rel_dds_a0",   dds_a,   32'd0);
        check("adder_57",     adder_b, 32'd18897);
        check("adder_81",     adder_c, 32'd75591);
        check("rel_dds_c0",   dds_c,   32'd0);
        tick();
        check("dds_a1", dds_a, 32'd37795);
        tick();
        check("dds_a2", dds_a, 32'd75590);

        // 69 -> 81: old slope for one more edge, then doubled, no phase jump.
        note_a = 8'd81;
        tick();
        check("sw_adder",  adder_a, 32'd75591);
        check("sw_dds_a3", dds_a,   32'd113385);
        tick();
        check("sw_dds_a4", dds_a,   32'd188976);

        // Top, bottom and out-of-range notes.
        note_a = 8'd127;
        tick();
        check("adder_127", adder_a, 32'd1077509);
        check("dds_a5",    dds_a,   32'd264567);
        note_a = 8'd0;
        tick();
        check("adder_0",   adder_a, 32'd702);
        check("dds_a6",    dds_a,   32'd1342076);
        note_a = 8'd200;
        tick();
        check("adder_200", adder_a, 32'd0);
        check("dds_a7",    dds_a,   32'd1342778);
        tick();
        check("hold_dds_1", dds_a, 32'd1342778);
        tick();
        check("hold_dds_2", dds_a, 32'd1342778);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_adder_a", adder_a, 32'd0);
        check("async_dds_a",   dds_a,   32'd0);
        check("async_adder_c", adder_c, 32'd0);
        check("async_dds_c",   dds_c,   32'd0);
        tick();
        check("rst_edge_dds_c", dds_c, 32'd0);

        // Parallel run: 93/105/117 should wrap in ratio 1:2:4.
        note_a = 8'd93;
        note_b = 8'd105;
        note_c = 8'd117;
        tick();
        rst_n = 1'b1;
        tick();
        check("adder_93",  adder_a, 32'd151182);
        check("adder_105", adder_b, 32'd302365);
        check("adder_117", adder_c, 32'd604731);
        inc_m[0] = 32'd151182;
        inc_m[1] = 32'd302365;
        inc_m[2] = 32'd604731;
        for (int k = 0; k < 3; k++) begin
            dds_m[k]    = 32'd0;
            prev_dut[k] = 32'd0;
            wraps_m[k]  = 0;
            wraps_d[k]  = 0;
        end
        wc_fail = 0;

        for (int cyc = 0; cyc < RUN_CYCLES; cyc++) begin
            tick();
            now_dut[0] = dds_a;
            now_dut[1] = dds_b;
            now_dut[2] = dds_c;
            for (int k = 0; k < 3; k++) begin
                sum_m    = {1'b0, dds_m[k]} + {1'b0, inc_m[k]};
                dds_m[k] = sum_m[31:0];
                if (sum_m[32]) begin
                    wraps_m[k]++;
                    // Value right after a wrap must be exactly (old + inc) mod 2^32.
                    if (k == 2) begin
                        check("wrap_value_c", now_dut[k], dds_m[k]);
                    end
                end
                if (now_dut[k] < prev_dut[k]) begin
                    wraps_d[k]++;
                end
                prev_dut[k] = now_dut[k];
            end
        end

        check("run_dds_a", dds_a, dds_m[0]);
        check("run_dds_b", dds_b, dds_m[1]);
        check("run_dds_c", dds_c, dds_m[2]);
        check("wraps_a", 32'(wraps_d[0]), 32'd2);
        check("wraps_b", 32'(wraps_d[1]), 32'd4);
        check("wraps_c", 32'(wraps_d[2]), 32'd8);
        check("ratio_b", 32'((wraps_d[1] >= 2 * wraps_d[0] - 1) && (wraps_d[1] <= 2 * wraps_d[0] + 1)), 32'd1);
        check("ratio_c", 32'((wraps_d[2] >= 4 * wraps_d[0] - 1) && (wraps_d[2] <= 4 * wraps_d[0] + 1)), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
